encrypt_function_1: RTL and testbench
=====================================

Name: encrypt_function_1

Overview:
- Encryption counterpart of the existing decrypt stage. It takes 60-bit plaintext words and draws an 11-bit key from an internal LFSR.
- It adds a key-derived 60-bit mask to the plaintext and emits the 78-bit frame the decrypt stage consumes: {cipher[60:0], key[10:0], seq[5:0]}.
- It is a 2-stage valid/ready pipeline with backpressure and sits between the plaintext source and the channel/decrypt side.

Parameters:
- SEED, 11'h5A5, LFSR reset value. If SEED is 0, 11'h001 is loaded instead.
- SEQ_INIT, 6'd0, sequence counter reset value.

Ports:
- Clk  input  1  clock; all state changes on the rising edge.
- Rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  data_in is valid.
- in_ready  output  1  block accepts data_in this cycle.
- data_in  input  60  plaintext word.
- out_valid  output  1  outEnc holds a valid frame.
- out_ready  input  1  downstream accepts outEnc.
- outEnc  output  78  encrypted frame.

Behaviour:
- Reset values, applied asynchronously on Rst=1:
  - s1_valid=0, out_valid=0, outEnc=0.
  - lfsr=SEED (or 1 if SEED=0), seq=SEQ_INIT.
  - in_ready=1 once Rst is released.
- Accept: an input is accepted when in_valid && in_ready on a rising edge.
- Stage 1 on accept registers:
  - x=data_in.
  - r=current lfsr.
  - sq=current seq.
  - Then lfsr advances once and seq increments mod 64.
- LFSR: next = {lfsr[9:0], lfsr[10]^lfsr[8]} (x^11+x^9+1, period 2047). It advances only on accept, never on stall. It never reaches 0.
- Stage 2, mask b(r), 60 bits:
  - b[10:0]=r, b[21:11]=~r, b[32:22]=~r.
  - b[43:33]=r, b[54:44]=~r, b[59:55]=r[4:0].
- Cipher: y = {1'b0,x} + {1'b0,b}, 61-bit unsigned, so the carry lands in y[60]. Invariant: decrypt(y - b)[59:0] == x.
- Output fields:
  - outEnc[77:17]=y.
  - outEnc[16:6]=r.
  - outEnc[5:0]=sq.
- Handshake:
  - s2_adv = !out_valid || out_ready.
  - in_ready = !s1_valid || s2_adv (combinational, no dependence on in_valid).
  - When s2_adv is true, stage 1 moves into the output register.
- Latency and throughput: 2 cycles from accept to out_valid when unstalled; 1 word/cycle sustained.
- Stall: while out_valid && !out_ready, outEnc and out_valid hold stable. Stage 1 holds; a new input is accepted only if stage 1 is empty.
- A transfer out and a new accept in the same cycle are both performed; no bubble is inserted.
- Rst mid-operation: all in-flight words are dropped and LFSR/seq return to their reset values. The first post-reset frame always uses key SEED.
- seq wraps 63 -> 0. The key sequence wraps after 2047 accepts.

Test Plan:
- Rst, then data_in=0 accepted -> 2 cycles later out_valid=1, outEnc[77:17]=61'h02A5AB4A9692D5A5, [16:6]=11'h5A5, [5:0]=0.
- Second word data_in=0 accepted immediately after the first -> key field 11'h34A, seq field 1; back-to-back out_valid with no gap.
- data_in=60'hFFF_FFFF_FFFF_FFFF with key 0x5A5 -> outEnc[77:17]=61'h12A5AB4A9692D5A4 (y[60]=1); subtracting b yields the original x.
- out_ready=0 for 5 cycles with 3 words offered -> exactly 2 accepted, in_ready=0 afterwards; outEnc stable throughout; release -> frames leave in order with keys 0x5A5, 0x34A.
- Assert Rst while 2 words are in flight -> out_valid drops immediately (async); next accepted word carries key 0x5A5, seq 0.
- Random 3000 words with random out_ready, results fed through the decrypt model -> every plaintext recovered in order; seq wraps at 64; key repeats after 2047 accepts.

Source files
------------

// File: rtl/encrypt_function_1.sv
// ============================================================================
// encrypt_function_1
// Two-stage valid/ready encryptor that adds an LFSR-keyed mask to plaintext.
// Revision: 1.0
// ============================================================================
`default_nettype none

module encrypt_function_1 #(
  parameter logic [10:0] SEED     = 11'h5A5,
  parameter logic [5:0]  SEQ_INIT = 6'd0
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [59:0] data_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [77:0] outEnc
);

  // An all-zero seed would lock the LFSR at zero forever.
  localparam logic [10:0] C_LFSR_RST = (SEED == 11'd0) ? 11'h001 : SEED;

  logic [10:0] lfsr_q;
  logic [10:0] lfsr_d;
  logic [5:0]  seq_q;
  logic [5:0]  seq_d;
  logic        s1_valid_q;
  logic [59:0] x_q;
  logic [10:0] r_q;
  logic [5:0]  sq_q;
  logic        out_valid_q;
  logic [77:0] out_q;

  logic        w_s2_adv;
  logic        w_accept;
  logic [59:0] w_mask;
  logic [60:0] w_y;

  always_comb begin
    w_s2_adv = !out_valid_q || out_ready;
    in_ready = !s1_valid_q || w_s2_adv;
    w_accept = in_valid && in_ready;
    lfsr_d   = {lfsr_q[9:0], lfsr_q[10] ^ lfsr_q[8]};
    seq_d    = seq_q + 6'd1;
    w_mask   = {r_q[4:0], ~r_q, r_q, ~r_q, ~r_q, r_q};
    // The carry is kept in bit 60 so the decrypt side can subtract exactly.
    w_y      = {1'b0, x_q} + {1'b0, w_mask};
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      lfsr_q      <= C_LFSR_RST;
      seq_q       <= SEQ_INIT;
      s1_valid_q  <= 1'b0;
      x_q         <= '0;
      r_q         <= '0;
      sq_q        <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      if (w_accept) begin
        x_q        <= data_in;
        r_q        <= lfsr_q;
        sq_q       <= seq_q;
        lfsr_q     <= lfsr_d;
        seq_q      <= seq_d;
        s1_valid_q <= 1'b1;
      end else if (w_s2_adv) begin
        s1_valid_q <= 1'b0;
      end

      if (w_s2_adv) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_q <= {w_y, r_q, sq_q};
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign outEnc    = out_q;

endmodule

`default_nettype wire

// File: tb/tb_encrypt_function_1.sv
// ============================================================================
// tb_encrypt_function_1
// Randomized and directed checks of encrypt_function_1 against a frame model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_encrypt_function_1;

  logic        Clk;
  logic        Rst;
  logic        in_valid;
  logic        in_ready;
  logic [59:0] data_in;
  logic        out_valid;
  logic        out_ready;
  logic [77:0] outEnc;

  int checks;
  int errors;

  logic [10:0] m_key;
  logic [5:0]  m_seq;
  logic [76:0] exp_q[$];
  logic [10:0] obs_key [0:2999];

  encrypt_function_1 dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .outEnc    (outEnc)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Mask built bit by bit: field f = i/11 is inverted for fields 1, 2 and 4.
  function automatic logic [59:0] mask_of(input logic [10:0] r);
    logic [59:0] m;
    m = '0;
    for (int i = 0; i < 60; i++) begin
      int f;
      int p;
      f = i / 11;
      p = i % 11;
      m[i] = (f == 1 || f == 2 || f == 4) ? ~r[p] : r[p];
    end
    return m;
  endfunction

  function automatic logic [77:0] frame_of(input logic [59:0] x, input logic [10:0] r,
                                           input logic [5:0] s);
    logic [60:0] y;
    y = {1'b0, x} + {1'b0, mask_of(r)};
    return {y, r, s};
  endfunction

  function automatic logic [59:0] decrypt(input logic [77:0] f);
    logic [60:0] y;
    logic [60:0] d;
    y = f[77:17];
    d = y - {1'b0, mask_of(f[16:6])};
    return d[59:0];
  endfunction

  function automatic logic [10:0] key_next(input logic [10:0] k);
    logic fb;
    fb = k[10] ^ k[8];
    return ((k << 1) & 11'h7FF) | {10'd0, fb};
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic apply_reset();
    Rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    data_in   = '0;
    step();
    step();
    Rst   = 1'b0;
    m_key = 11'h5A5;
    m_seq = 6'd0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    Rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    data_in   = '0;
    #3;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid got %0b want 0", out_valid);
    end
    checks++;
    if (outEnc !== 78'd0) begin
      errors++;
      $display("FAIL reset_outEnc got %h want 0", outEnc);
    end
    step();
    Rst = 1'b0;
    #2;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %0b want 1", in_ready);
    end
    step();
  endtask

  task automatic test_first_frames();
    logic [77:0] want;
    apply_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    data_in   = '0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL first_latency got out_valid=%0b want 0", out_valid);
    end
    step();
    in_valid = 1'b0;
    want = {61'h02A5AB4A9692D5A5, 11'h5A5, 6'd0};
    checks++;
    if (out_valid !== 1'b1 || outEnc !== want) begin
      errors++;
      $display("FAIL first_frame got v=%0b %h want v=1 %h", out_valid, outEnc, want);
    end
    step();
    want = frame_of(60'd0, 11'h34A, 6'd1);
    checks++;
    if (out_valid !== 1'b1 || outEnc !== want) begin
      errors++;
      $display("FAIL second_frame got v=%0b %h want v=1 %h", out_valid, outEnc, want);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty got out_valid=%0b want 0", out_valid);
    end
  endtask

  task automatic test_carry();
    logic [59:0] x;
    apply_reset();
    x         = 60'hFFF_FFFF_FFFF_FFFF;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    data_in   = x;
    step();
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b1 || outEnc[77:17] !== 61'h12A5AB4A9692D5A4 || outEnc[77] !== 1'b1) begin
      errors++;
      $display("FAIL carry_cipher got v=%0b %h want v=1 %h", out_valid, outEnc[77:17],
               61'h12A5AB4A9692D5A4);
    end
    checks++;
    if (decrypt(outEnc) !== x) begin
      errors++;
      $display("FAIL carry_decrypt got %h want %h", decrypt(outEnc), x);
    end
    step();
  endtask

  task automatic test_stall();
    logic [59:0] words [0:2];
    logic [77:0] held;
    int          idx;
    int          accepted;
    int          moved;
    apply_reset();
    words[0]  = 60'h123_4567_89AB_CDEF;
    words[1]  = 60'h0F0_F0F0_F0F0_F0F0;
    words[2]  = 60'hABC_DEF0_1234_5678;
    idx       = 0;
    accepted  = 0;
    moved     = 0;
    held      = '0;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = (idx < 3);
      data_in  = words[idx < 3 ? idx : 2];
      #2;
      if (out_valid && held !== outEnc && c > 2) moved++;
      if (in_valid && in_ready) begin
        accepted++;
        idx++;
      end
      step();
      if (c == 2) held = outEnc;
    end
    in_valid = 1'b0;
    checks++;
    if (accepted !== 2) begin
      errors++;
      $display("FAIL stall_accepts got %0d want 2", accepted);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_in_ready got %0b want 0", in_ready);
    end
    checks++;
    if (moved !== 0 || outEnc !== held || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_hold got changes=%0d v=%0b want changes=0 v=1", moved, out_valid);
    end
    out_ready = 1'b1;
    #2;
    checks++;
    if (outEnc !== frame_of(words[0], 11'h5A5, 6'd0)) begin
      errors++;
      $display("FAIL stall_release0 got %h want %h", outEnc, frame_of(words[0], 11'h5A5, 6'd0));
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || outEnc !== frame_of(words[1], 11'h34A, 6'd1)) begin
      errors++;
      $display("FAIL stall_release1 got v=%0b %h want v=1 %h", out_valid, outEnc,
               frame_of(words[1], 11'h34A, 6'd1));
    end
    step();
  endtask

  task automatic test_reset_midflight();
    logic [59:0] x;
    apply_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    data_in   = 60'h555_5555_5555_5555;
    step();
    data_in = 60'h0AA_AAAA_AAAA_AAAA;
    step();
    in_valid = 1'b0;
    #2;
    Rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || outEnc !== 78'd0) begin
      errors++;
      $display("FAIL midreset_async got v=%0b %h want v=0 0", out_valid, outEnc);
    end
    step();
    Rst       = 1'b0;
    x         = 60'h321_0FED_CBA9_8765;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    data_in   = x;
    step();
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b1 || outEnc !== frame_of(x, 11'h5A5, 6'd0)) begin
      errors++;
      $display("FAIL midreset_restart got v=%0b %h want v=1 %h", out_valid, outEnc,
               frame_of(x, 11'h5A5, 6'd0));
    end
    step();
  endtask

  task automatic test_random();
    logic [63:0] t;
    logic [76:0] e;
    logic [77:0] want;
    int          sent;
    int          got;
    int          cyc;
    int          bad_frame;
    int          bad_dec;
    int          bad_seq;
    int          bad_key;
    apply_reset();
    sent      = 0;
    got       = 0;
    cyc       = 0;
    bad_frame = 0;
    bad_dec   = 0;
    bad_seq   = 0;
    bad_key   = 0;
    while (got < 3000 && cyc < 30000) begin
      t         = {$urandom(), $urandom()};
      in_valid  = (sent < 3000) && ($urandom_range(0, 9) < 8);
      data_in   = t[59:0];
      out_ready = ($urandom_range(0, 9) < 7);
      #2;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          bad_frame++;
          if (bad_frame < 5) $display("FAIL rand_spurious got %h want no frame", outEnc);
        end else begin
          e    = exp_q.pop_front();
          want = frame_of(e[76:17], e[16:6], e[5:0]);
          if (outEnc !== want) begin
            bad_frame++;
            if (bad_frame < 5) $display("FAIL rand_frame got %h want %h", outEnc, want);
          end
          if (decrypt(outEnc) !== e[76:17]) begin
            bad_dec++;
            if (bad_dec < 5)
              $display("FAIL rand_decrypt got %h want %h", decrypt(outEnc), e[76:17]);
          end
        end
        if (outEnc[5:0] !== 6'(got % 64)) begin
          bad_seq++;
          if (bad_seq < 5) $display("FAIL rand_seq got %0d want %0d", outEnc[5:0], got % 64);
        end
        obs_key[got] = outEnc[16:6];
        if (got >= 2047 && obs_key[got] !== obs_key[got - 2047]) begin
          bad_key++;
          if (bad_key < 5)
            $display("FAIL rand_key_period got %h want %h", obs_key[got], obs_key[got - 2047]);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({data_in, m_key, m_seq});
        m_key = key_next(m_key);
        m_seq = m_seq + 6'd1;
        sent++;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (got !== 3000) begin
      errors++;
      $display("FAIL rand_timeout got %0d frames want 3000", got);
    end
    checks++;
    if (bad_frame !== 0) begin
      errors++;
      $display("FAIL rand_frames got %0d bad want 0", bad_frame);
    end
    checks++;
    if (bad_dec !== 0) begin
      errors++;
      $display("FAIL rand_recover got %0d bad want 0", bad_dec);
    end
    checks++;
    if (bad_seq !== 0) begin
      errors++;
      $display("FAIL rand_seq_wrap got %0d bad want 0", bad_seq);
    end
    checks++;
    if (bad_key !== 0) begin
      errors++;
      $display("FAIL rand_key_wrap got %0d bad want 0", bad_key);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    m_key     = 11'h5A5;
    m_seq     = 6'd0;
    Rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    data_in   = '0;
    test_reset();
    test_first_frames();
    test_carry();
    test_stall();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
